// File: rtl/adc_avg_sequencer.sv
// Periodic AD7606 conversion sequencer with power-of-two boxcar averaging.
// Define ADC_AVG_SIGNED_EN to treat samples as two's-complement (bipolar range).
module adc_avg_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_LOG2      = 3,
    parameter int ACK_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_flags,
    output logic        adc_start,
    input  logic        adc_busy,
    input  logic [15:0] adc_data,
    output logic [15:0] avg_data,
    output logic        avg_valid,
    output logic        overrun,
    output logic        ack_err
);
    localparam int DATA_W = 16;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int PER_W  = $clog2(SAMPLE_PERIOD);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TRIG, S_ACK, S_CONV} state_t;

    state_t             state, state_nxt;
    logic [PER_W-1:0]   per_cnt;
    logic [ACK_W-1:0]   ack_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   smp_cnt;
    logic [ACC_W-1:0]   sum_p0;
    logic               tick, ack_timeout, capture;

`ifdef ADC_AVG_SIGNED_EN
    function automatic logic [ACC_W-1:0] ext_sample(input logic [DATA_W-1:0] d);
        logic signed [DATA_W-1:0] s;
        s = d;
        return ACC_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] avg_shift(input logic [ACC_W-1:0] total);
        logic signed [ACC_W-1:0] s;
        s = total;
        return DATA_W'(s >>> AVG_LOG2);
    endfunction
`else
    function automatic logic [ACC_W-1:0] ext_sample(input logic [DATA_W-1:0] d);
        return ACC_W'(d);
    endfunction

    function automatic logic [DATA_W-1:0] avg_shift(input logic [ACC_W-1:0] total);
        return DATA_W'(total >> AVG_LOG2);
    endfunction
`endif

    assign tick        = enable && (per_cnt == PER_LAST);
    assign ack_timeout = (state == S_ACK) && !adc_busy && (ack_cnt >= ACK_LAST);
    assign capture     = (state == S_CONV) && !adc_busy;
    assign sum_p0      = acc + ext_sample(adc_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (!enable || per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // Ack timer starts at the start pulse, so the limit covers TRIG plus ACK cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state == S_TRIG || state == S_ACK) begin
            ack_cnt <= ack_cnt + ACK_W'(1);
        end else begin
            ack_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!enable)   state_nxt = S_IDLE;
                else if (tick) state_nxt = S_TRIG;
            end
            S_TRIG: state_nxt = S_ACK;
            S_ACK: begin
                if (adc_busy)         state_nxt = S_CONV;
                else if (ack_timeout) state_nxt = S_WAIT;
            end
            S_CONV: if (!adc_busy) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        adc_start = (state == S_TRIG);
    end

    // Capture stage -> averaged output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            smp_cnt   <= '0;
            avg_data  <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (state == S_WAIT && !enable) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (capture) begin
                if (smp_cnt == CNT_LAST) begin
                    avg_data  <= avg_shift(sum_p0);
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    smp_cnt   <= '0;
                end else begin
                    acc     <= sum_p0;
                    smp_cnt <= smp_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Set takes priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            if (tick && state != S_WAIT) overrun <= 1'b1;
            else if (clr_flags)          overrun <= 1'b0;
            if (ack_timeout)             ack_err <= 1'b1;
            else if (clr_flags)          ack_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Directed bench for adc_avg_sequencer (SAMPLE_PERIOD=20, AVG_LOG2=2), modelling the ADC controller.
module tb_adc_avg_sequencer;
    logic        clk = 1'b0;
    logic        rst, enable, clr_flags, adc_start, adc_busy;
    logic [15:0] adc_data, avg_data;
    logic        avg_valid, overrun, ack_err;
    logic        started;
    int          checks = 0;
    int          errors = 0;
    int          w;

    always #5 clk = ~clk;

    adc_avg_sequencer #(
        .SAMPLE_PERIOD(20),
        .AVG_LOG2     (2),
        .ACK_TIMEOUT  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clr_flags(clr_flags),
        .adc_start(adc_start),
        .adc_busy (adc_busy),
        .adc_data (adc_data),
        .avg_data (avg_data),
        .avg_valid(avg_valid),
        .overrun  (overrun),
        .ack_err  (ack_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int limit, output int waited);
        waited = 0;
        while (adc_start !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk(tag, 32'(waited < limit), 1);
    endtask

    // Called in the start cycle T: busy high T+1..T+3, data presented with busy low at T+4, returns at T+5.
    task automatic convert(input logic [15:0] d);
        @(negedge clk);
        adc_busy = 1'b1;
        chk("start_one_cycle", adc_start, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        adc_busy = 1'b0;
        adc_data = d;
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] d, input logic last);
        int n;
        wait_start("start_seen", 100, n);
        convert(d);
        chk("avg_valid_strobe", avg_valid, last);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clr_flags = 1'b0; adc_busy = 1'b0; adc_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_adc_start", adc_start, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ack_err", ack_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic average and first-trigger latency
        enable = 1'b1;
        wait_start("first_start_seen", 100, w);
        chk("first_start_delay", w, 20);
        convert(16'd100);
        chk("avg_valid_strobe", avg_valid, 0);
        feed(16'd200, 1'b0);
        feed(16'd300, 1'b0);
        feed(16'd400, 1'b1);
        chk("basic_avg", avg_data, 250);
        @(negedge clk);
        chk("valid_single_cycle", avg_valid, 0);
        chk("avg_hold", avg_data, 250);

        // Full-scale, no wrap
        repeat (3) feed(16'hFFFF, 1'b0);
        feed(16'hFFFF, 1'b1);
        chk("full_scale_avg", avg_data, 16'hFFFF);

        // Sign handling
        feed(16'hFFFC, 1'b0);
        feed(16'hFFFC, 1'b0);
        feed(16'h0004, 1'b0);
        feed(16'h0004, 1'b1);
`ifdef ADC_AVG_SIGNED_EN
        chk("sign_avg", avg_data, 16'h0000);
`else
        chk("sign_avg", avg_data, 16'h8000);
`endif

        // Overrun: busy held for 30 cycles spans a tick
        wait_start("ovr_start_seen", 100, w);
        @(negedge clk);
        adc_busy = 1'b1;
        started = 1'b0;
        repeat (29) begin
            @(negedge clk);
            if (adc_start) started = 1'b1;
        end
        chk("no_start_while_busy", started, 0);
        chk("overrun_set", overrun, 1);
        @(negedge clk);
        adc_busy = 1'b0;
        adc_data = 16'd5;
        @(negedge clk);
        chk("ovr_no_valid", avg_valid, 0);
        clr_flags = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Ack timeout: busy never rises
        enable = 1'b1;
        wait_start("ack_start_seen", 100, w);
        chk("ack_start_delay", w, 20);
        repeat (7) @(negedge clk);
        chk("ack_err_not_yet", ack_err, 0);
        @(negedge clk);
        chk("ack_err_set", ack_err, 1);
        wait_start("ack_retry_seen", 100, w);
        chk("ack_retry_delay", w, 12);
        convert(16'd0);
        clr_flags = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("ack_err_cleared", ack_err, 0);

        // Enable drop discards the partial average
        enable = 1'b1;
        feed(16'd1000, 1'b0);
        feed(16'd1000, 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        feed(16'd8, 1'b0);
        feed(16'd8, 1'b0);
        feed(16'd8, 1'b0);
        feed(16'd8, 1'b1);
        chk("reenable_avg", avg_data, 8);

        // Asynchronous reset in the middle of a conversion
        wait_start("rst_start_seen", 100, w);
        @(negedge clk);
        adc_busy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midconv_adc_start", adc_start, 0);
        chk("midconv_avg_data", avg_data, 0);
        chk("midconv_avg_valid", avg_valid, 0);
        chk("midconv_overrun", overrun, 0);
        chk("midconv_ack_err", ack_err, 0);
        @(negedge clk);
        rst = 1'b0;
        adc_busy = 1'b0;
        enable = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_avg_sequencer.md
Name: adc_avg_sequencer

Overview:
- Sits beside the AD7606 ADC controller and drives it.
- Issues periodic single-cycle start pulses to the controller, watches the controller's busy signal and captures each completed 16-bit sample.
- Boxcar-averages 2^AVG_LOG2 consecutive samples and presents one averaged word with a single-cycle valid strobe to downstream logic.
- Flags trigger overruns and handshake timeouts.

Parameters:
- SAMPLE_PERIOD, 1000, clk cycles between conversion triggers; legal range ≥ 16.
- AVG_LOG2, 3, log2 of samples per average; legal range 0..8 (AVG_LOG2=0 means every sample passes straight through).
- ACK_TIMEOUT, 8, max cycles to wait for busy to rise after start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  run sampling while high
- clr_flags  in  1  synchronous clear of the sticky flags
- adc_start  out  1  start pulse to the ADC controller
- adc_busy  in  1  busy from the ADC controller
- adc_data  in  16  data from the ADC controller; valid once busy has fallen
- avg_data  out  16  averaged sample
- avg_valid  out  1  one-cycle strobe; avg_data is new in this cycle
- overrun  out  1  sticky: a trigger tick was dropped
- ack_err  out  1  sticky: busy never rose after a start

Behaviour:
- Reset (async, rst=1):
  - State IDLE; period counter, accumulator and sample count all 0.
  - adc_start=0, avg_data=0, avg_valid=0, overrun=0, ack_err=0.
  - Reset mid-conversion abandons the conversion; the partial average is discarded.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1; held at 0 while enable=0.
  - A tick occurs in the cycle the counter equals SAMPLE_PERIOD-1.
  - The first tick comes SAMPLE_PERIOD cycles after enable rises.
- FSM states:
  - IDLE: waiting for enable. If enable=1 → WAIT.
  - WAIT: if enable=0 → IDLE, clearing accumulator and sample count. Otherwise, on a tick → TRIG.
  - TRIG: adc_start=1 for exactly this one cycle → ACK. adc_start is 0 in every other state.
  - ACK: waiting for adc_busy=1.
    - adc_busy=1 → CONV.
    - If ACK_TIMEOUT cycles pass without busy, set ack_err and go to WAIT; no sample is taken.
  - CONV: waiting for adc_busy=0. In the cycle busy is sampled 0, capture adc_data into the accumulator → WAIT.
- Tick while state ≠ WAIT: the tick is dropped, overrun is set, and no extra start is issued. The period counter keeps running.
- Enable falling during TRIG, ACK or CONV:
  - The in-flight handshake completes and its sample is accumulated.
  - The FSM then goes to WAIT, where enable=0 sends it to IDLE and clears the partial average.
- Arithmetic:
  - Accumulator width is 16+AVG_LOG2, so no overflow is possible.
  - On the capture that completes sample count 2^AVG_LOG2-1:
    - avg_data = (acc + sample) >> AVG_LOG2 (truncating).
    - avg_valid=1 on the next cycle only.
    - Accumulator and sample count are reset to 0 on the same edge.
  - Latency: avg_valid is high in the cycle after busy is sampled low for the final sample.
  - avg_data holds its value between strobes.
- Flags:
  - clr_flags=1 clears overrun and ack_err.
  - If clr_flags and a set event occur in the same cycle, set wins.

Optional Feature:
- Macro: ADC_AVG_SIGNED_EN.
- Defined:
  - adc_data is treated as two's-complement (AD7606 bipolar range).
  - Samples are sign-extended into the accumulator.
  - The final shift is arithmetic and avg_data is signed.
- Undefined:
  - Samples are unsigned and zero-extended; the shift is logical.

Test Plan (SAMPLE_PERIOD=20, AVG_LOG2=2, bench models the controller: busy rises 1 cycle after start, falls 3 cycles later):
- Basic average: enable=1; samples 100,200,300,400 → one avg_valid pulse with avg_data=250; first adc_start pulse 20 cycles after enable.
- Full-scale: four samples of 0xFFFF, macro undefined → avg_data=0xFFFF, no wrap.
- Sign handling: samples 0xFFFC,0xFFFC,0x0004,0x0004 → avg_data=0x0000 with ADC_AVG_SIGNED_EN defined; avg_data=0x8000 without it.
- Overrun: model holds busy high for 30 cycles on one conversion → overrun=1, no adc_start while busy; clr_flags pulse → overrun=0.
- Ack timeout: model never raises busy → ack_err=1 exactly 8 cycles after adc_start; next tick issues a new adc_start.
- Enable drop: enable=0 after 2 samples, then re-enable; feed 4 samples of 8 → avg_data=8, with no contribution from the earlier samples. Also assert rst mid-CONV → all outputs 0 immediately.
